// File: rtl/tilemap_cpu_port.sv
// CPU/video time-slice responder for one tilemap layer pair on the System86 master bus.
// Shares one tile VRAM between the CPU (2H high) and tile fetches (2H low); scroll latches are double-buffered.
module tilemap_cpu_port #(
   parameter int ADDR_WIDTH     = 13,
   parameter int SCROLL_X_WIDTH = 9,
   parameter int VBLANK_COPY    = 1
) (
   input  logic                      CLK_6M,
   input  logic                      rst,
   input  logic                      CLK_2H,
   input  logic                      nVBLANK,
   input  logic [ADDR_WIDTH-1:0]     A,
   inout  wire  [7:0]                D,
   input  logic                      RnW,
   input  logic                      nSCROLL,
   input  logic                      nLATCH,
   output logic [ADDR_WIDTH-1:0]     vram_addr,
   output logic [7:0]                vram_din,
   input  logic [7:0]                vram_dout,
   output logic                      vram_we_n,
   output logic                      vram_oe_n,
   input  logic                      vid_req,
   input  logic [ADDR_WIDTH-1:0]     vid_addr,
   output logic [7:0]                vid_data,
   output logic                      vid_valid,
   output logic [SCROLL_X_WIDTH-1:0] scroll_x0,
   output logic [SCROLL_X_WIDTH-1:0] scroll_x1,
   output logic [7:0]                scroll_y0,
   output logic [7:0]                scroll_y1
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_C0   = 3'd1,
      ST_C1   = 3'd2,
      ST_V0   = 3'd3,
      ST_V1   = 3'd4
   } slot_e;

   slot_e                     state_r;
   slot_e                     next_state_s;
   logic                      clk2h_r;
   logic                      nvb_r;
   logic                      sync_r;
   logic                      cyc_rd_r;
   logic                      cyc_wr_r;
   logic                      fetch_r;
   logic [7:0]                rd_hold_r;
   logic [SCROLL_X_WIDTH-1:0] sh_x_r  [2];
   logic [7:0]                sh_y_r  [2];
   logic [SCROLL_X_WIDTH-1:0] act_x_r [2];
   logic [7:0]                act_y_r [2];
   logic                      rise_s;
   logic                      fall_s;
   logic                      vb_fall_s;
   logic                      cpu_vram_s;
   logic                      latch_wr_s;
   logic                      c0_to_c1_s;
   logic                      leave_v1_s;
   logic                      d_drive_s;
   logic                      layer_s;

   // sync_r suppresses a false phase edge on the first cycle out of reset
   assign rise_s     = sync_r & CLK_2H & ~clk2h_r;
   assign fall_s     = sync_r & ~CLK_2H & clk2h_r;
   assign vb_fall_s  = sync_r & nvb_r & ~nVBLANK;
   assign cpu_vram_s = ~nSCROLL & nLATCH;
   assign latch_wr_s = ~nLATCH & ~RnW;
   assign c0_to_c1_s = (state_r == ST_C0) && (next_state_s == ST_C1);
   assign leave_v1_s = (state_r == ST_V1) && (next_state_s != ST_V1);
   assign layer_s    = A[2];
   assign d_drive_s  = ~rst & CLK_2H & ~nSCROLL & nLATCH & RnW;

   assign D = d_drive_s ? rd_hold_r : 8'bzzzz_zzzz;

   assign scroll_x0 = act_x_r[0];
   assign scroll_x1 = act_x_r[1];
   assign scroll_y0 = act_y_r[0];
   assign scroll_y1 = act_y_r[1];

   // Slot sequencing: phase edges win over holding in C1/V1
   always_comb begin
      next_state_s = state_r;
      if (rise_s) begin
         next_state_s = ST_C0;
      end else if (fall_s) begin
         next_state_s = ST_V0;
      end else begin
         case (state_r)
            ST_C0:   next_state_s = ST_C1;
            ST_C1:   next_state_s = ST_C1;
            ST_V0:   next_state_s = ST_V1;
            ST_V1:   next_state_s = ST_V1;
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   // Slot state and input edge history
   always_ff @(posedge CLK_6M or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         clk2h_r <= 1'b0;
         nvb_r   <= 1'b1;
         sync_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         clk2h_r <= CLK_2H;
         nvb_r   <= nVBLANK;
         sync_r  <= 1'b1;
      end
   end

   // VRAM port: controls are set on entry to each slot state so they are valid for that whole cycle
   always_ff @(posedge CLK_6M or posedge rst) begin
      if (rst) begin
         vram_addr <= {ADDR_WIDTH{1'b0}};
         vram_din  <= 8'h00;
         vram_we_n <= 1'b1;
         vram_oe_n <= 1'b1;
         vid_data  <= 8'h00;
         vid_valid <= 1'b0;
         rd_hold_r <= 8'h00;
         cyc_rd_r  <= 1'b0;
         cyc_wr_r  <= 1'b0;
         fetch_r   <= 1'b0;
      end else begin
         vid_valid <= 1'b0;
         case (next_state_s)
            ST_C0: begin
               vram_we_n <= 1'b1;
               cyc_rd_r  <= cpu_vram_s & RnW;
               cyc_wr_r  <= cpu_vram_s & ~RnW;
               if (cpu_vram_s) begin
                  vram_addr <= A;
                  vram_oe_n <= ~RnW;
                  if (!RnW) begin
                     vram_din <= D;
                  end
               end else begin
                  vram_oe_n <= 1'b1;
               end
            end
            ST_C1: begin
               // strobe only if the write is still being requested one cycle after the address phase
               if (state_r == ST_C0) begin
                  vram_we_n <= ~(cyc_wr_r & cpu_vram_s & ~RnW);
                  if (cyc_rd_r) begin
                     rd_hold_r <= vram_dout;
                  end
               end else begin
                  vram_we_n <= 1'b1;
               end
            end
            ST_V0: begin
               vram_we_n <= 1'b1;
               fetch_r   <= vid_req;
               vram_oe_n <= ~vid_req;
               if (vid_req) begin
                  vram_addr <= vid_addr;
               end
            end
            ST_V1: begin
               vram_we_n <= 1'b1;
            end
            default: begin
               vram_we_n <= 1'b1;
               vram_oe_n <= 1'b1;
            end
         endcase
         if (leave_v1_s) begin
            vid_valid <= fetch_r;
            fetch_r   <= 1'b0;
            if (fetch_r) begin
               vid_data <= vram_dout;
            end
         end
      end
   end

   // Scroll shadow writes and shadow-to-active transfer; the copy reads the pre-write shadow value
   always_ff @(posedge CLK_6M or posedge rst) begin
      if (rst) begin
         sh_x_r[0]  <= {SCROLL_X_WIDTH{1'b0}};
         sh_x_r[1]  <= {SCROLL_X_WIDTH{1'b0}};
         sh_y_r[0]  <= 8'h00;
         sh_y_r[1]  <= 8'h00;
         act_x_r[0] <= {SCROLL_X_WIDTH{1'b0}};
         act_x_r[1] <= {SCROLL_X_WIDTH{1'b0}};
         act_y_r[0] <= 8'h00;
         act_y_r[1] <= 8'h00;
      end else begin
         if (c0_to_c1_s && latch_wr_s) begin
            case (A[1:0])
               2'd0:    sh_x_r[layer_s][SCROLL_X_WIDTH-1:8] <= D[SCROLL_X_WIDTH-9:0];
               2'd1:    sh_x_r[layer_s][7:0] <= D;
               2'd2:    sh_y_r[layer_s] <= D;
               default: begin end
            endcase
         end
         if (VBLANK_COPY != 0) begin
            if (vb_fall_s) begin
               act_x_r[0] <= sh_x_r[0];
               act_x_r[1] <= sh_x_r[1];
               act_y_r[0] <= sh_y_r[0];
               act_y_r[1] <= sh_y_r[1];
            end
         end else begin
            act_x_r[0] <= sh_x_r[0];
            act_x_r[1] <= sh_x_r[1];
            act_y_r[0] <= sh_y_r[0];
            act_y_r[1] <= sh_y_r[1];
         end
      end
   end

endmodule

// File: doc/tilemap_cpu_port.md
Name: tilemap_cpu_port

Overview:
CPU-facing responder of one tilemap layer pair on the shared System86 master bus. It decodes nSCROLL/nLATCH strobes driven by the CPU subsystem, services VRAM reads and writes in the CPU half of the 2H time slice, and serves tile fetches in the video half. Scroll latches are double-buffered into shadow registers and copied to the active set at vblank start. Sits between the master bus and one tile VRAM plus its tilemap generator.

Parameters:
ADDR_WIDTH, 13, master bus / VRAM address width
SCROLL_X_WIDTH, 9, horizontal scroll register width
VBLANK_COPY, 1, 1 = shadow→active copy on nVBLANK fall; 0 = active follows shadow one cycle after a write

Ports:
CLK_6M  in  1  pixel clock, sole clock
rst  in  1  asynchronous, active-high reset
CLK_2H  in  1  slice phase, synchronous to CLK_6M: high = CPU slot, low = video slot
nVBLANK  in  1  active-low vblank
A  in  ADDR_WIDTH  master bus address
D  inout  8  master bus data
RnW  in  1  1 = read, 0 = write
nSCROLL  in  1  VRAM window select, active low
nLATCH  in  1  scroll-latch select, active low
vram_addr  out  ADDR_WIDTH  VRAM address
vram_din  out  8  VRAM write data
vram_dout  in  8  VRAM read data
vram_we_n  out  1  VRAM write strobe, active low
vram_oe_n  out  1  VRAM output enable, active low
vid_req  in  1  tilemap generator fetch request
vid_addr  in  ADDR_WIDTH  fetch address
vid_data  out  8  fetched byte
vid_valid  out  1  one-cycle fetch-complete pulse
scroll_x0, scroll_x1  out  SCROLL_X_WIDTH  active horizontal scroll, layers 0/1
scroll_y0, scroll_y1  out  8  active vertical scroll, layers 0/1

Behaviour:
- Reset (async): vram_we_n=1, vram_oe_n=1, vram_addr=0, vram_din=0, vid_data=0, vid_valid=0, all shadow and active scroll registers = 0, D high-Z, slot FSM = IDLE.
- Slot FSM, registered on CLK_6M. States: IDLE, C0, C1, V0, V1. A CLK_2H low→high (sampled) enters C0, then C1. A CLK_2H high→low enters V0, then V1. If CLK_2H stays in a phase beyond 2 cycles, the FSM holds in C1/V1. In C1/V1, the opposite phase edge takes priority.
- CPU read (C0, nSCROLL=0, nLATCH=1, RnW=1): vram_addr<=A and vram_oe_n<=0 in C0. rd_hold<=vram_dout at the end of C0. D=rd_hold while CLK_2H=1 && nSCROLL=0 && RnW=1; otherwise D is high-Z. vram_oe_n returns to 1 on leaving C1.
- CPU write (nSCROLL=0, RnW=0): vram_addr<=A and vram_din<=D in C0. vram_we_n=0 for exactly the C1 cycle, only if nSCROLL is still 0 and RnW is still 0 in C1. Otherwise the write aborts and no strobe is issued.
- Latch write (nLATCH=0, RnW=0, sampled in C1): one register update per CPU slot. A[2] selects the layer. A[1:0] selects the register:
  - 0 → x[8] ← D[0]
  - 1 → x[7:0] ← D
  - 2 → y ← D
  - 3 → ignored
- Latch reads return D high-Z.
- nLATCH and nSCROLL both low: the latch wins and VRAM is untouched (we_n/oe_n stay 1).
- Video slot: in V0, if vid_req=1, vram_addr<=vid_addr and vram_oe_n<=0. At the end of V1, vid_data<=vram_dout, and vid_valid pulses high for 1 cycle (the cycle after V1). If vid_req=0, there is no fetch and no pulse.
- Fetch latency: vid_req sampled in V0 → vid_valid 2 cycles later.
- Vblank copy (VBLANK_COPY=1): on the nVBLANK 1→0 edge (sampled), active<=shadow. If a latch write occurs in the same cycle, the copy takes the pre-write shadow value and the new value appears at the next vblank.
- Reset mid-slot: strobes deassert immediately, and the FSM restarts at the next CLK_2H edge.

Test Plan:
- Write then read: CPU writes 0xA5 to A=0x0123 in slot N → vram_we_n low for exactly 1 cycle, with vram_addr=0x0123 and vram_din=0xA5. A read of 0x0123 in slot N+1 → D=0xA5 during CLK_2H high, and D is high-Z otherwise.
- Abort: nSCROLL rises after C0 of a write → vram_we_n stays 1 and VRAM is unchanged.
- Scroll latch: write D=0x01 at A=4, D=0x3C at A=5, D=0x77 at A=6 → no active change before vblank. After the nVBLANK fall: scroll_x1=0x13C, scroll_y1=0x77, and layer 0 stays 0.
- Same-cycle collision: a latch write to y0=0x55 lands in the nVBLANK-fall cycle → scroll_y0 keeps its old value, then becomes 0x55 after the next vblank.
- Video fetch: vid_req=1, vid_addr=0x1FFF, VRAM holds 0x3E → vid_data=0x3E and a single vid_valid pulse 2 cycles after V0. With vid_req=0 there is no pulse.
- Async reset asserted during C1 of a write → vram_we_n=1 immediately and all scroll outputs read 0.
